// File: rtl/i2c_target_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM-emulating target.
package i2c_target_eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_e;

  localparam logic       RW_READ          = 1'b1;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;
  localparam logic [3:0] LAST_BIT         = 4'd7;

  // True when the received address byte selects this target (R/W bit ignored).
  function automatic logic devAddrMatch(input logic [7:0] addrByte, input logic [6:0] devAddr);
    return addrByte[7:1] == devAddr;
  endfunction

endpackage

// File: rtl/i2c_target_eeprom_bus_cond.sv
// I2C bus conditioner: synchronises SCL/SDA and flags SCL edges plus START/STOP.
module i2c_target_eeprom_bus_cond (
  input  logic I_CLK,
  input  logic I_RESETN,
  input  logic I_SCL,
  input  logic I_SDA,
  output logic O_SDA,
  output logic O_SCL_RISE,
  output logic O_SCL_FALL,
  output logic O_START,
  output logic O_STOP
);

  logic [1:0] sclSync_q;
  logic [1:0] sdaSync_q;
  logic       sclPrev_q;
  logic       sdaPrev_q;
  logic       sclNow;
  logic       sdaNow;

  // Two-flop synchronisers followed by a previous-value stage; reset to idle-high bus.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      sclSync_q <= 2'b11;
      sdaSync_q <= 2'b11;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclSync_q <= {sclSync_q[0], I_SCL};
      sdaSync_q <= {sdaSync_q[0], I_SDA};
      sclPrev_q <= sclSync_q[1];
      sdaPrev_q <= sdaSync_q[1];
    end
  end

  assign sclNow     = sclSync_q[1];
  assign sdaNow     = sdaSync_q[1];
  assign O_SDA      = sdaNow;
  assign O_SCL_RISE = sclNow & ~sclPrev_q;
  assign O_SCL_FALL = ~sclNow & sclPrev_q;
  assign O_START    = sclNow & sclPrev_q & sdaPrev_q & ~sdaNow;
  assign O_STOP     = sclNow & sclPrev_q & ~sdaPrev_q & sdaNow;

endmodule

// File: rtl/i2c_target_eeprom.sv
// I2C target emulating a 24Cxx-style byte-addressed EEPROM on an internal register array.
module i2c_target_eeprom
  import i2c_target_eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic              I_CLK,
  input  logic              I_RESETN,
  input  logic              I_SCL,
  input  logic              I_SDA,
  output logic              O_SDA_OE,
  output logic              O_BUSY,
  output logic              O_WR_STB,
  output logic [ADDR_W-1:0] O_WR_ADDR,
  output logic [7:0]        O_WR_DATA,
  input  logic [ADDR_W-1:0] I_DBG_ADDR,
  output logic [7:0]        O_DBG_DATA
);

  localparam int DEPTH = 1 << ADDR_W;

  logic sdaNow, sclRise, sclFall, busStart, busStop;

  i2c_target_eeprom_bus_cond u_bus_cond (
    .I_CLK      (I_CLK),
    .I_RESETN   (I_RESETN),
    .I_SCL      (I_SCL),
    .I_SDA      (I_SDA),
    .O_SDA      (sdaNow),
    .O_SCL_RISE (sclRise),
    .O_SCL_FALL (sclFall),
    .O_START    (busStart),
    .O_STOP     (busStop)
  );

  state_e            state_q,  state_d;
  logic [7:0]        shift_q,  shift_d;
  logic [3:0]        bitCnt_q, bitCnt_d;
  logic [ADDR_W-1:0] ptr_q,    ptr_d;
  logic              sdaOe_q,  sdaOe_d;
  logic              busy_q,   busy_d;
  logic              wrStb_q,  wrStb_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [7:0]        wrData_q, wrData_d;

  logic              memWe;
  logic [ADDR_W-1:0] memWAddr;
  logic [7:0]        memWData;
  logic [7:0]        rdByte;
  logic [7:0]        shiftIn;

  // Contents come from configuration only; reset leaves the array untouched.
  logic [7:0] mem_q [DEPTH] = '{default: INIT_VAL};

  assign rdByte     = mem_q[ptr_q];
  assign shiftIn    = {shift_q[6:0], sdaNow};
  assign O_DBG_DATA = mem_q[I_DBG_ADDR];
  assign O_SDA_OE   = sdaOe_q;
  assign O_BUSY     = busy_q;
  assign O_WR_STB   = wrStb_q;
  assign O_WR_ADDR  = wrAddr_q;
  assign O_WR_DATA  = wrData_q;

  // Protocol state and datapath registers; reset releases SDA at once.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      state_q  <= ST_IDLE;
      shift_q  <= 8'h00;
      bitCnt_q <= 4'd0;
      ptr_q    <= '0;
      sdaOe_q  <= 1'b0;
      busy_q   <= 1'b0;
      wrStb_q  <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      ptr_q    <= ptr_d;
      sdaOe_q  <= sdaOe_d;
      busy_q   <= busy_d;
      wrStb_q  <= wrStb_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
    end
  end

  // Memory write port, fired on the 8th SCL rise of a data byte.
  always_ff @(posedge I_CLK) begin
    if (memWe) mem_q[memWAddr] <= memWData;
  end

  // Next-state logic: bus conditions override bit handling; ACK phases count fall/rise/fall.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    ptr_d    = ptr_q;
    sdaOe_d  = sdaOe_q;
    busy_d   = busy_q;
    wrStb_d  = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    memWe    = 1'b0;
    memWAddr = ptr_q;
    memWData = shiftIn;

    if (busStop) begin
      state_d  = ST_IDLE;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
      bitCnt_d = 4'd0;
    end else if (busStart) begin
      state_d  = ST_DEV_ADDR;
      sdaOe_d  = 1'b0;
      bitCnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_DEV_ADDR: begin
          if (sclRise) begin
            shift_d  = shiftIn;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_d = 4'd0;
              if (devAddrMatch(shiftIn, DEV_ADDR)) begin
                state_d = ST_DEV_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
        end
        ST_DEV_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (sclFall && bitCnt_q == 4'd0) begin
            sdaOe_d  = 1'b1;
            bitCnt_d = 4'd1;
          end else if (sclRise && bitCnt_q == 4'd1) begin
            bitCnt_d = 4'd2;
          end else if (sclFall && bitCnt_q == 4'd2) begin
            sdaOe_d  = 1'b0;
            bitCnt_d = 4'd0;
            if (state_q == ST_DEV_ACK && shift_q[0] == RW_READ) begin
              state_d = ST_RDATA;
              shift_d = rdByte;
              sdaOe_d = ~rdByte[7];
            end else if (state_q == ST_DEV_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_PTR: begin
          if (sclRise) begin
            shift_d  = shiftIn;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_d = 4'd0;
              ptr_d    = shiftIn[ADDR_W-1:0];
              state_d  = ST_PTR_ACK;
            end
          end
        end
        ST_WDATA: begin
          if (sclRise) begin
            shift_d  = shiftIn;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_d = 4'd0;
              memWe    = 1'b1;
              wrStb_d  = 1'b1;
              wrAddr_d = ptr_q;
              wrData_d = shiftIn;
              ptr_d    = ptr_q + 1'b1;
              state_d  = ST_WDATA_ACK;
            end
          end
        end
        ST_RDATA: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_d = 4'd0;
              state_d  = ST_RDATA_ACK;
            end
          end else if (sclFall) begin
            shift_d = {shift_q[6:0], 1'b0};
            sdaOe_d = ~shift_q[6];
          end
        end
        ST_RDATA_ACK: begin
          if (sclFall && bitCnt_q == 4'd0) begin
            sdaOe_d  = 1'b0;
            bitCnt_d = 4'd1;
          end else if (sclRise && bitCnt_q == 4'd1) begin
            if (sdaNow) begin
              state_d  = ST_WAIT_STOP;
              busy_d   = 1'b0;
              bitCnt_d = 4'd0;
            end else begin
              ptr_d    = ptr_q + 1'b1;
              bitCnt_d = 4'd2;
            end
          end else if (sclFall && bitCnt_q == 4'd2) begin
            state_d  = ST_RDATA;
            shift_d  = rdByte;
            sdaOe_d  = ~rdByte[7];
            bitCnt_d = 4'd0;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          sdaOe_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          sdaOe_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_eeprom.sv
// Directed bench: bit-banged I2C master against the EEPROM target.
module tb_i2c_target_eeprom;

  localparam int QNS = 200;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sclM = 1'b1;
  logic       sdaM = 1'b1;
  logic [7:0] dbgAddr = 8'h00;
  wire        busSda;
  logic       oe, busy, wrStb;
  logic [7:0] wrAddr, wrData, dbgData;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;
  int wrCount = 0;
  int sdaGlitches = 0;
  logic [7:0] lastAddr = 8'h00;
  logic [7:0] lastData = 8'h00;
  bit allowSda = 1'b1;

  assign busSda = sdaM & ~oe;

  i2c_target_eeprom dut (
    .I_CLK      (clk),
    .I_RESETN   (rstn),
    .I_SCL      (sclM),
    .I_SDA      (busSda),
    .O_SDA_OE   (oe),
    .O_BUSY     (busy),
    .O_WR_STB   (wrStb),
    .O_WR_ADDR  (wrAddr),
    .O_WR_DATA  (wrData),
    .I_DBG_ADDR (dbgAddr),
    .O_DBG_DATA (dbgData)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  // Record every memory write strobe with its address and data
  always @(posedge clk) begin
    if (wrStb === 1'b1) begin
      wrCount++;
      lastAddr = wrAddr;
      lastData = wrData;
    end
  end

  // SDA must not move while SCL is high except for deliberate START/STOP
  always @(busSda) begin
    if (sclM && !allowSda) sdaGlitches++;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkDbg(input string tag, input logic [7:0] addr, input logic [7:0] expected);
    dbgAddr = addr;
    #2;
    checkOutput(tag, dbgData, expected);
    #18;
  endtask

  // One SCL clock from SCL low: set SDA mid-low, sample mid-high
  task automatic applyStimulus(input logic bitVal, output logic sampled);
    #(QNS) sdaM = bitVal;
    #(QNS) sclM = 1'b1;
    #(QNS) sampled = busSda;
    #(QNS) sclM = 1'b0;
  endtask

  task automatic i2cStart();
    sdaM = 1'b1;
    #(QNS) sclM = 1'b1;
    #(QNS) allowSda = 1'b1;
    sdaM = 1'b0;
    #(QNS) allowSda = 1'b0;
    sclM = 1'b0;
  endtask

  task automatic i2cStop();
    #(QNS) sdaM = 1'b0;
    #(QNS) sclM = 1'b1;
    #(QNS) allowSda = 1'b1;
    sdaM = 1'b1;
    #(QNS) allowSda = 1'b0;
  endtask

  task automatic writeByte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) applyStimulus(b[i], s);
    applyStimulus(1'b1, s);
    acked = (s == 1'b0);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, s);
      d = {d[6:0], s};
    end
    applyStimulus(nack, s);
  endtask

  initial begin
    logic a0, a1, a2, a3;
    logic [7:0] rd;

    // Reset state
    rstn = 1'b0;
    #35;
    checkOutput("rst_oe", {7'd0, oe}, 8'h00);
    checkOutput("rst_busy", {7'd0, busy}, 8'h00);
    checkOutput("rst_wrstb", {7'd0, wrStb}, 8'h00);
    checkOutput("rst_wraddr", wrAddr, 8'h00);
    checkOutput("rst_wrdata", wrData, 8'h00);
    checkDbg("init_mem5", 8'h05, 8'h00);
    rstn = 1'b1;
    allowSda = 1'b0;
    #(4*QNS);

    // Test 1: byte write 0x06 to address 0x00
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'h00, a1);
    writeByte(8'h06, a2);
    checkOutput("t1_acks", {5'd0, a0, a1, a2}, 8'h07);
    checkOutput("t1_busy", {7'd0, busy}, 8'h01);
    i2cStop();
    #(QNS);
    checkOutput("t1_busy_after", {7'd0, busy}, 8'h00);
    checkOutput("t1_wrcount", 8'(wrCount), 8'd1);
    checkOutput("t1_wraddr", lastAddr, 8'h00);
    checkOutput("t1_wrdata", lastData, 8'h06);
    checkDbg("t1_dbg0", 8'h00, 8'h06);

    // Test 2: random read of address 0x00
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'h00, a1);
    i2cStart();
    writeByte(8'hA1, a2);
    checkOutput("t2_acks", {5'd0, a0, a1, a2}, 8'h07);
    readByte(1'b1, rd);
    checkOutput("t2_rd", rd, 8'h06);
    checkOutput("t2_oe_released", {7'd0, oe}, 8'h00);
    i2cStop();
    #(QNS);
    checkOutput("t2_busy", {7'd0, busy}, 8'h00);

    // Test 3: write 0xFE..0x00 with wrap, then sequential read across the wrap
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'hFE, a1);
    writeByte(8'h11, a2);
    writeByte(8'h22, a3);
    writeByte(8'h33, a3);
    i2cStop();
    #(QNS);
    checkOutput("t3_wrcount", 8'(wrCount), 8'd4);
    checkOutput("t3_lastaddr", lastAddr, 8'h00);
    checkDbg("t3_dbgFE", 8'hFE, 8'h11);
    checkDbg("t3_dbgFF", 8'hFF, 8'h22);
    checkDbg("t3_dbg00", 8'h00, 8'h33);
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'hFE, a1);
    i2cStart();
    writeByte(8'hA1, a2);
    readByte(1'b0, rd);
    checkOutput("t3_rd0", rd, 8'h11);
    readByte(1'b0, rd);
    checkOutput("t3_rd1", rd, 8'h22);
    readByte(1'b1, rd);
    checkOutput("t3_rd2", rd, 8'h33);
    i2cStop();

    // Test 4: wrong address is not acknowledged and writes nothing
    i2cStart();
    writeByte(8'hA2, a0);
    checkOutput("t4_nack", {7'd0, a0}, 8'h00);
    checkOutput("t4_busy", {7'd0, busy}, 8'h00);
    writeByte(8'h00, a1);
    writeByte(8'h55, a2);
    checkOutput("t4_ignored_acks", {6'd0, a1, a2}, 8'h00);
    i2cStop();
    #(QNS);
    checkOutput("t4_wrcount", 8'(wrCount), 8'd4);
    checkDbg("t4_dbg00", 8'h00, 8'h33);

    // Test 5: STOP mid-byte aborts the write and keeps the pointer
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'h10, a1);
    writeByte(8'h5A, a2);
    i2cStop();
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'h10, a1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, a3);
    i2cStop();
    #(QNS);
    checkOutput("t5_wrcount", 8'(wrCount), 8'd5);
    checkDbg("t5_dbg10", 8'h10, 8'h5A);
    i2cStart();
    writeByte(8'hA1, a0);
    readByte(1'b1, rd);
    checkOutput("t5_rd_current", rd, 8'h5A);
    i2cStop();

    // Test 6: reset while the target drives a 0 data bit
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'h00, a1);
    i2cStart();
    writeByte(8'hA1, a2);
    #(QNS);
    checkOutput("t6_oe_driving", {7'd0, oe}, 8'h01);
    rstn = 1'b0;
    #1;
    checkOutput("t6_oe_reset", {7'd0, oe}, 8'h00);
    checkOutput("t6_busy_reset", {7'd0, busy}, 8'h00);
    #39;
    rstn = 1'b1;
    #(QNS);
    i2cStart();
    writeByte(8'hA0, a0);
    writeByte(8'h20, a1);
    checkOutput("t6_acks_after", {6'd0, a0, a1}, 8'h03);
    i2cStop();
    #(QNS);
    checkOutput("t6_wrcount", 8'(wrCount), 8'd5);
    checkDbg("t6_mem_kept", 8'h00, 8'h33);

    checkOutput("sda_stable_scl_high", 8'(sdaGlitches), 8'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
